fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_if.sv | 45 ++++
 rtl/fetch_unit.sv | 118 +++++++++++
 tb/tb_fetch_unit.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction-memory request/response, redirect and
// instruction-out handshakes; master = fetch unit, slave = environment.
interface fetch_unit_if #(
  parameter int WIDTH = 32
);
  logic             imem_req_valid;
  logic             imem_req_ready;
  logic [WIDTH-1:0] imem_addr;
  logic             imem_resp_valid;
  logic [WIDTH-1:0] imem_resp_data;
  logic             redirect_valid;
  logic [WIDTH-1:0] redirect_pc;
  logic             inst_valid;
  logic             inst_ready;
  logic [WIDTH-1:0] inst_data;
  logic [WIDTH-1:0] inst_pc;

  modport master (
    output imem_req_valid,
    input  imem_req_ready,
    output imem_addr,
    input  imem_resp_valid,
    input  imem_resp_data,
    input  redirect_valid,
    input  redirect_pc,
    output inst_valid,
    input  inst_ready,
    output inst_data,
    output inst_pc
  );

  modport slave (
    input  imem_req_valid,
    output imem_req_ready,
    input  imem_addr,
    output imem_resp_valid,
    output imem_resp_data,
    output redirect_valid,
    output redirect_pc,
    input  inst_valid,
    output inst_ready,
    input  inst_data,
    input  inst_pc
  );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: credit-based instruction fetcher with a DEPTH-entry buffer.
// Ports: clk, rst (async, active-high), bus (fetch_unit_if.master).
module fetch_unit #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  parameter int               DEPTH    = 2
) (
  input logic          clk,
  input logic          rst,
  fetch_unit_if.master bus
);
  localparam int CW  = $clog2(DEPTH + 1);
  localparam int CW1 = CW + 1;
  localparam int PW  = $clog2(DEPTH);
  localparam logic [CW:0]   DEPTH_W = CW1'(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [PW-1:0] LAST    = PW'(DEPTH - 1);

  logic [WIDTH-1:0] fetch_pc;
  logic [WIDTH-1:0] resp_pc;
  logic [CW-1:0]    count;
  // out_cnt: every issued request not yet answered,
  // drop_cnt: the oldest of those, which are stale
  logic [CW-1:0]    out_cnt;
  logic [CW-1:0]    drop_cnt;
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic [WIDTH-1:0] buf_data [DEPTH];
  logic [WIDTH-1:0] buf_pc   [DEPTH];

  logic             issue;
  logic             resp_take;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] target;

  function automatic logic [PW-1:0] nxt(
    input logic [PW-1:0] p
  );
    return (p == LAST) ? '0 : p + PW'(1);
  endfunction

  assign target = {bus.redirect_pc[WIDTH-1:2], 2'b00};

  // Credits count stale in-flight requests too,
  // so valid only drops through an issue or redirect.
  assign bus.imem_req_valid =
    !rst && !bus.redirect_valid &&
    (({1'b0, count} + {1'b0, out_cnt}) < DEPTH_W);
  assign bus.imem_addr = fetch_pc;

  assign issue =
    bus.imem_req_valid && bus.imem_req_ready;
  // A response with nothing in flight is ignored.
  assign resp_take =
    bus.imem_resp_valid && (out_cnt != '0);
  assign push =
    resp_take && (drop_cnt == '0) &&
    !bus.redirect_valid;
  assign pop =
    bus.inst_valid && bus.inst_ready &&
    !bus.redirect_valid;

  assign bus.inst_valid = (count != '0);
  assign bus.inst_data  = buf_data[head];
  assign bus.inst_pc    = buf_pc[head];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      resp_pc  <= RESET_PC;
      count    <= '0;
      out_cnt  <= '0;
      drop_cnt <= '0;
      head     <= '0;
      tail     <= '0;
    end else if (bus.redirect_valid) begin
      fetch_pc <= target;
      resp_pc  <= target;
      count    <= '0;
      head     <= '0;
      tail     <= '0;
      // Everything still in flight becomes stale.
      out_cnt  <= out_cnt - CW'(resp_take);
      drop_cnt <= out_cnt - CW'(resp_take);
    end else begin
      if (issue) begin
        fetch_pc <= fetch_pc + WIDTH'(4);
      end
      if (push) begin
        resp_pc <= resp_pc + WIDTH'(4);
        tail    <= nxt(tail);
      end
      if (pop) begin
        head <= nxt(head);
      end
      count   <= count + CW'(push) - CW'(pop);
      out_cnt <= out_cnt + CW'(issue)
               - CW'(resp_take);
      if (resp_take && (drop_cnt != '0)) begin
        drop_cnt <= drop_cnt - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      buf_data[tail] <= bus.imem_resp_data;
      buf_pc[tail]   <= resp_pc;
    end
  end

  a_no_overflow: assert property (
    @(posedge clk) disable iff (rst)
    !(push && !pop && (count == DEPTH_C))
  );

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed fetch scenarios plus a randomized
// memory/redirect run, checked against an in-order pc scoreboard.
module tb_fetch_unit;
  localparam int          W   = 32;
  localparam logic [31:0] RPC = 32'h100;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fetch_unit_if #(.WIDTH(W)) bus ();

  fetch_unit #(
    .WIDTH(W),
    .RESET_PC(RPC),
    .DEPTH(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(
    input string       tag,
    input logic [63:0] act,
    input logic [63:0] exp
  );
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h",
               tag, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(
    input logic [31:0] a
  );
    return {a[15:0], a[31:16]} ^ 32'hdead_beef;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(
    input string tag,
    input int    lim
  );
    int k = 0;
    @(negedge clk);
    while (!bus.inst_valid && k < lim) begin
      @(negedge clk);
      k++;
    end
    chk(tag, bus.inst_valid, 1);
  endtask

  // memory model: in-order, latency lat_min..lat_max
  // mode 0: never ready, 1: always ready, 2: random
  typedef struct {
    logic [31:0] addr;
    int          due;
  } req_t;

  req_t q[$];
  int   cyc     = 0;
  int   mode    = 1;
  int   lat_min = 1;
  int   lat_max = 1;

  initial begin
    bus.imem_req_ready  = 1'b0;
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data  = '0;
    forever begin
      @(posedge clk);
      #2;
      cyc++;
      bus.imem_req_ready = (mode == 2) ?
        1'($urandom_range(0, 1)) : (mode == 1);
      if (q.size() > 0 && q[0].due <= cyc
          && !rst) begin
        bus.imem_resp_valid = 1'b1;
        bus.imem_resp_data  = mem_word(q[0].addr);
        void'(q.pop_front());
      end else begin
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_data  = '0;
      end
      @(negedge clk);
      if (rst) begin
        q.delete();
      end else if (bus.imem_req_valid &&
                   bus.imem_req_ready) begin
        q.push_back('{bus.imem_addr, cyc +
          int'($urandom_range(lat_min, lat_max))});
      end
    end
  end

  // scoreboard and handshake-stability monitor
  logic [31:0] exp_pc = RPC;
  int          n_del  = 0;
  logic        pq_w   = 1'b0;
  logic [31:0] pq_a   = '0;
  logic        pi_w   = 1'b0;
  logic [31:0] pi_pc  = '0;
  logic [31:0] pi_d   = '0;

  always @(negedge clk) begin
    if (rst) begin
      exp_pc = RPC;
      pq_w   = 1'b0;
      pi_w   = 1'b0;
    end else begin
      if (pq_w && !bus.redirect_valid) begin
        chk("req_hold_valid",
            bus.imem_req_valid, 1);
        chk("req_hold_addr", bus.imem_addr, pq_a);
      end
      if (pi_w) begin
        chk("inst_hold_valid", bus.inst_valid, 1);
        chk("inst_hold_pc", bus.inst_pc, pi_pc);
        chk("inst_hold_data", bus.inst_data, pi_d);
      end
      if (bus.redirect_valid) begin
        exp_pc = {bus.redirect_pc[31:2], 2'b00};
      end else if (bus.inst_valid &&
                   bus.inst_ready) begin
        chk("sb_pc", bus.inst_pc, exp_pc);
        chk("sb_data", bus.inst_data,
            mem_word(bus.inst_pc));
        exp_pc = exp_pc + 32'd4;
        n_del++;
      end
      pq_w  = bus.imem_req_valid &&
              !bus.imem_req_ready &&
              !bus.redirect_valid;
      pq_a  = bus.imem_addr;
      pi_w  = bus.inst_valid && !bus.inst_ready &&
              !bus.redirect_valid;
      pi_pc = bus.inst_pc;
      pi_d  = bus.inst_data;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] base;
    int          d0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.inst_ready     = 1'b0;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_valid", bus.imem_req_valid, 0);
    chk("rst_inst_valid", bus.inst_valid, 0);

    // first request and streaming
    step();
    rst            = 1'b0;
    bus.inst_ready = 1'b1;
    @(negedge clk);
    chk("first_req_valid", bus.imem_req_valid, 1);
    chk("first_addr", bus.imem_addr, RPC);
    wait_valid("stream_fill", 10);
    for (int i = 0; i < 6; i++) begin
      chk("stream_valid", bus.inst_valid, 1);
      chk("stream_pc", bus.inst_pc,
          RPC + 32'(4 * i));
      @(negedge clk);
    end

    // backpressure
    step();
    bus.inst_ready = 1'b0;
    repeat (10) step();
    @(negedge clk);
    chk("bp_valid", bus.inst_valid, 1);
    chk("bp_req_valid", bus.imem_req_valid, 0);
    chk("bp_pc", bus.inst_pc, exp_pc);
    base = exp_pc;
    step();
    bus.inst_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("drain_valid", bus.inst_valid, 1);
      chk("drain_pc", bus.inst_pc,
          base + 32'(4 * i));
    end

    // redirect with two requests in flight
    step();
    mode    = 0;
    lat_min = 3;
    lat_max = 3;
    repeat (8) step();
    mode = 1;
    step();
    step();
    mode               = 0;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h2002;
    @(negedge clk);
    chk("rd_no_issue", bus.imem_req_valid, 0);
    step();
    bus.redirect_valid = 1'b0;
    mode    = 1;
    lat_min = 1;
    lat_max = 1;
    wait_valid("rd_fill", 20);
    chk("rd_pc0", bus.inst_pc, 32'h2000);
    chk("rd_data0", bus.inst_data,
        mem_word(32'h2000));
    wait_valid("rd_fill1", 10);
    chk("rd_pc1", bus.inst_pc, 32'h2004);

    // redirect with pop and response same cycle
    repeat (4) step();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h4000;
    @(negedge clk);
    chk("r39_head_valid", bus.inst_valid, 1);
    step();
    bus.redirect_valid = 1'b0;
    @(negedge clk);
    chk("r39_flush", bus.inst_valid, 0);
    wait_valid("r39_fill", 10);
    chk("r39_pc", bus.inst_pc, 32'h4000);
    chk("r39_data", bus.inst_data,
        mem_word(32'h4000));

    // pc wrap at top of address space
    step();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'hffff_fff9;
    step();
    bus.redirect_valid = 1'b0;
    wait_valid("wrap_fill0", 10);
    chk("wrap_pc0", bus.inst_pc, 32'hffff_fff8);
    wait_valid("wrap_fill1", 10);
    chk("wrap_pc1", bus.inst_pc, 32'hffff_fffc);
    wait_valid("wrap_fill2", 10);
    chk("wrap_pc2", bus.inst_pc, 32'h0);

    // async reset between edges
    repeat (5) step();
    #2;
    rst = 1'b1;
    #1;
    chk("arst_inst_valid", bus.inst_valid, 0);
    chk("arst_req_valid", bus.imem_req_valid, 0);
    repeat (2) step();
    rst = 1'b0;
    @(negedge clk);
    chk("arst_req_after", bus.imem_req_valid, 1);
    chk("arst_addr", bus.imem_addr, RPC);
    wait_valid("arst_fill", 10);
    chk("arst_pc", bus.inst_pc, RPC);

    // random latency, ready and redirects
    step();
    mode    = 2;
    lat_min = 1;
    lat_max = 4;
    for (int i = 0; i < 1500; i++) begin
      step();
      bus.inst_ready =
        ($urandom_range(0, 3) != 0);
      bus.redirect_valid =
        ($urandom_range(0, 15) == 0);
      bus.redirect_pc = $urandom;
    end
    step();
    bus.redirect_valid = 1'b0;
    bus.inst_ready     = 1'b1;
    mode               = 1;
    d0                 = n_del;
    repeat (20) step();
    @(negedge clk);
    chk("rand_progress", (n_del - d0) > 5, 1);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end
endmodule
